// File: rtl/junofirst_sndcmd_tx_if.sv
// Sound-command link bundle: main-CPU write side plus sound-board latch/IRQ side.
// drop_cnt exists only when SNDCMD_DROP_CNT_EN is defined; fsm_state is a debug view of the FSM.
`timescale 1ns/1ps
interface junofirst_sndcmd_tx_if #(
  parameter int FIFO_AW = 2
);
  // cmd_wr is a valid-only strobe with no back-pressure: a byte is taken unless fifo_full is set
  // and no pop coincides, in which case it is dropped and recorded in overflow (and drop_cnt).
  logic             cmd_wr;
  logic [7:0]       cmd_din;
  logic             flush;
  logic             cs_sounddata;
  logic [7:0]       cpubrd_Din;
  logic             irq_trigger;
  logic [FIFO_AW:0] fifo_level;
  logic             fifo_full;
  logic             fifo_empty;
  logic             busy;
  logic             overflow;
`ifdef SNDCMD_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif
  logic [1:0]       fsm_state;

`ifdef SNDCMD_DROP_CNT_EN
  modport master (output cmd_wr, cmd_din, flush,
                  input  cs_sounddata, cpubrd_Din, irq_trigger, fifo_level, fifo_full,
                         fifo_empty, busy, overflow, drop_cnt, fsm_state);
  modport slave  (input  cmd_wr, cmd_din, flush,
                  output cs_sounddata, cpubrd_Din, irq_trigger, fifo_level, fifo_full,
                         fifo_empty, busy, overflow, drop_cnt, fsm_state);
`else
  modport master (output cmd_wr, cmd_din, flush,
                  input  cs_sounddata, cpubrd_Din, irq_trigger, fifo_level, fifo_full,
                         fifo_empty, busy, overflow, fsm_state);
  modport slave  (input  cmd_wr, cmd_din, flush,
                  output cs_sounddata, cpubrd_Din, irq_trigger, fifo_level, fifo_full,
                         fifo_empty, busy, overflow, fsm_state);
`endif
endinterface

// File: rtl/junofirst_sndcmd_tx.sv
// Juno First main-board sound-command transmitter: queues 6809 command bytes and replays each as a
// soundlatch write plus IRQ pulse with a guaranteed gap. Optional drop counter: SNDCMD_DROP_CNT_EN.
`timescale 1ns/1ps
module junofirst_sndcmd_tx #(
  parameter int FIFO_AW   = 2,
  parameter int IRQ_HOLD  = 16,
  parameter int GAP_TICKS = 2048
) (
  input  logic                 clk_49m,
  input  logic                 reset,
  input  logic                 cen_3m,
  junofirst_sndcmd_tx_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int MAX_T = (IRQ_HOLD > GAP_TICKS) ? IRQ_HOLD : GAP_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(IRQ_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LATCH = 2'd1, TRIG = 2'd2, GAP = 2'd3} state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             cs_q, cs_n, irq_q, irq_n;
  logic [7:0]       din_q, din_n;
  logic             pop, push, drop;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q, wr_ptr_n, rd_ptr_n, level_n;
  logic [FIFO_AW:0] level_q;
  logic             full_q, empty_q, full_n, busy_q, ovf_q;

  // FSM next-state and output logic; flush overrides everything except an ongoing GAP countdown.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    cs_n    = cs_q;
    irq_n   = irq_q;
    din_n   = din_q;
    pop     = 1'b0;
    if (bus.flush && state_q != GAP) begin
      cs_n = 1'b0;
      if (state_q != IDLE) begin
        irq_n   = 1'b0;
        cnt_n   = GAP_LD;
        state_n = GAP;
      end
    end else if (cen_3m) begin
      case (state_q)
        IDLE: begin
          if (!empty_q) begin
            pop     = 1'b1;
            din_n   = mem[rd_ptr_q[FIFO_AW-1:0]];
            cs_n    = 1'b1;
            state_n = LATCH;
          end
        end
        LATCH: begin
          cs_n    = 1'b0;
          irq_n   = 1'b1;
          cnt_n   = HOLD_LD;
          state_n = TRIG;
        end
        TRIG: begin
          if (cnt_q == '0) begin
            irq_n   = 1'b0;
            cnt_n   = GAP_LD;
            state_n = GAP;
          end else begin
            cnt_n = cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == '0) state_n = IDLE;
          else             cnt_n   = cnt_q - 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    push     = bus.cmd_wr && !bus.flush && (!full_q || pop);
    drop     = bus.cmd_wr && !bus.flush && full_q && !pop;
    wr_ptr_n = bus.flush ? '0 : wr_ptr_q + (FIFO_AW+1)'(push);
    rd_ptr_n = bus.flush ? '0 : rd_ptr_q + (FIFO_AW+1)'(pop);
    level_n  = wr_ptr_n - rd_ptr_n;
    full_n   = (wr_ptr_n[FIFO_AW] != rd_ptr_n[FIFO_AW]) &&
               (wr_ptr_n[FIFO_AW-1:0] == rd_ptr_n[FIFO_AW-1:0]);
  end

  always_ff @(posedge clk_49m) begin
    if (push) mem[wr_ptr_q[FIFO_AW-1:0]] <= bus.cmd_din;
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cs_q     <= 1'b0;
      irq_q    <= 1'b0;
      din_q    <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      cs_q     <= cs_n;
      irq_q    <= irq_n;
      din_q    <= din_n;
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      level_q  <= level_n;
      full_q   <= full_n;
      empty_q  <= (wr_ptr_n == rd_ptr_n);
      busy_q   <= (state_n != IDLE);
      ovf_q    <= ovf_q | drop;
    end
  end

`ifdef SNDCMD_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset)                           drop_cnt_q <= 8'h00;
    else if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'h01;
  end
  assign bus.drop_cnt = drop_cnt_q;
`endif

  assign bus.cs_sounddata = cs_q;
  assign bus.cpubrd_Din   = din_q;
  assign bus.irq_trigger  = irq_q;
  assign bus.fifo_level   = level_q;
  assign bus.fifo_full    = full_q;
  assign bus.fifo_empty   = empty_q;
  assign bus.busy         = busy_q;
  assign bus.overflow     = ovf_q;
  assign bus.fsm_state    = state_q;
endmodule

// File: tb/tb_junofirst_sndcmd_tx.sv
// Directed bench for junofirst_sndcmd_tx; GAP_TICKS is shortened to 64 so the burst stays brief.
// All waits are bounded; every check is an immediate assertion feeding one pass/fail tally.
`timescale 1ns/1ps
module tb_junofirst_sndcmd_tx;
  localparam int FIFO_AW   = 2;
  localparam int IRQ_HOLD  = 16;
  localparam int GAP_TICKS = 64;
  localparam int TICK      = 16;
  localparam int PERIOD    = (2 + IRQ_HOLD + GAP_TICKS) * TICK;
  localparam int BUDGET    = 4000;

  logic       clk_49m = 1'b0;
  logic       reset   = 1'b0;
  logic       cen_3m  = 1'b0;
  logic [3:0] div     = 4'd0;
  int         cyc     = 0;
  int         n_cmp   = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  junofirst_sndcmd_tx_if #(.FIFO_AW(FIFO_AW)) sif ();

  junofirst_sndcmd_tx #(.FIFO_AW(FIFO_AW), .IRQ_HOLD(IRQ_HOLD), .GAP_TICKS(GAP_TICKS)) dut (
    .clk_49m(clk_49m),
    .reset  (reset),
    .cen_3m (cen_3m),
    .bus    (sif)
  );

  // clock / reset / clock-enable block
  always #5 clk_49m = ~clk_49m;
  always @(posedge clk_49m) begin
    cyc    <= cyc + 1;
    div    <= div + 4'd1;
    cen_3m <= (div == 4'd15);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return sif.cs_sounddata;
      1:       return sif.irq_trigger;
      default: return sif.busy;
    endcase
  endfunction

  // driver tasks; all start and end at a negedge
  task automatic wait_cen();
    int n = 0;
    do begin @(negedge clk_49m); n++; end while (!cen_3m && n < 40);
  endtask

  task automatic wait_for(input string tag, input int sel, input logic val, output int waited);
    waited = 0;
    while (sig(sel) !== val && waited < BUDGET) begin @(negedge clk_49m); waited++; end
    if (sig(sel) !== val) check({tag, "_timeout"}, {31'd0, sig(sel)}, {31'd0, val});
  endtask

  task automatic count_while(input int sel, input logic val, output int n, output int ncen);
    n = 0; ncen = 0;
    while (sig(sel) === val && n < BUDGET) begin
      if (cen_3m) ncen++;
      @(negedge clk_49m);
      n++;
    end
  endtask

  task automatic wr(input logic [7:0] d);
    sif.cmd_wr = 1'b1; sif.cmd_din = d;
    @(negedge clk_49m);
    sif.cmd_wr = 1'b0;
  endtask

  // scoreboard: each latch strobe must carry the oldest expected byte
  task automatic sb_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else                   e = 8'hxx;
    check(tag, {24'd0, sif.cpubrd_Din}, {24'd0, e});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"},    {31'd0, sif.cs_sounddata}, 0);
    check({tag, "_irq"},   {31'd0, sif.irq_trigger}, 0);
    check({tag, "_din"},   {24'd0, sif.cpubrd_Din}, 0);
    check({tag, "_level"}, {29'd0, sif.fifo_level}, 0);
    check({tag, "_empty"}, {31'd0, sif.fifo_empty}, 1);
    check({tag, "_full"},  {31'd0, sif.fifo_full}, 0);
    check({tag, "_busy"},  {31'd0, sif.busy}, 0);
    check({tag, "_ovf"},   {31'd0, sif.overflow}, 0);
    check({tag, "_state"}, {30'd0, sif.fsm_state}, 0);
`ifdef SNDCMD_DROP_CNT_EN
    check({tag, "_dropcnt"}, {24'd0, sif.drop_cnt}, 0);
`endif
  endtask

  initial begin
    int w, n, nc, t0;
    sif.cmd_wr = 1'b0; sif.cmd_din = 8'h00; sif.flush = 1'b0;
    repeat (3) @(negedge clk_49m);
    check_reset_vals("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk_49m);

    // single command into an idle block
    wait_cen(); @(negedge clk_49m);
    exp_q.push_back(8'hA5); wr(8'hA5);
    check("single_level", {29'd0, sif.fifo_level}, 1);
    wait_for("single_cs", 0, 1'b1, w);
    check("single_latency", w, 15);
    sb_check("single_data");
    check("single_busy", {31'd0, sif.busy}, 1);
    count_while(0, 1'b1, n, nc);
    check("single_cs_len", n, TICK);
    check("single_cs_cen", nc, 1);
    check("single_irq_rise", {31'd0, sif.irq_trigger}, 1);
    count_while(1, 1'b1, n, nc);
    check("single_irq_len", n, IRQ_HOLD * TICK);
    count_while(2, 1'b1, n, nc);
    check("single_gap_len", n, GAP_TICKS * TICK);

    // burst fill, overflow, then back-to-back drain with a pop-coincident write while full
    wait_cen(); @(negedge clk_49m);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i)); wr(8'(i));
    end
    check("burst_level", {29'd0, sif.fifo_level}, 4);
    check("burst_full", {31'd0, sif.fifo_full}, 1);
    wr(8'h05);
    check("ovf_flag", {31'd0, sif.overflow}, 1);
    check("ovf_level", {29'd0, sif.fifo_level}, 4);
`ifdef SNDCMD_DROP_CNT_EN
    check("ovf_dropcnt", {24'd0, sif.drop_cnt}, 1);
`endif
    wait_for("burst_cs0", 0, 1'b1, w);
    sb_check("burst_data0");
    check("burst_level_pop", {29'd0, sif.fifo_level}, 3);
    exp_q.push_back(8'h06); wr(8'h06);
    check("burst_refull", {31'd0, sif.fifo_full}, 1);
    wait_for("burst_irq0", 1, 1'b1, w);
    t0 = cyc;
    wait_for("burst_idle", 2, 1'b0, w);
    wait_cen();
    exp_q.push_back(8'h07);
    sif.cmd_wr = 1'b1; sif.cmd_din = 8'h07;
    @(negedge clk_49m);
    sif.cmd_wr = 1'b0;
    check("popfull_level", {29'd0, sif.fifo_level}, 4);
    check("popfull_full", {31'd0, sif.fifo_full}, 1);
    check("popfull_cs", {31'd0, sif.cs_sounddata}, 1);
`ifdef SNDCMD_DROP_CNT_EN
    check("popfull_dropcnt", {24'd0, sif.drop_cnt}, 1);
`endif
    sb_check("burst_data1");
    wait_for("burst_irq1", 1, 1'b1, w);
    check("burst_spacing1", cyc - t0, PERIOD);
    t0 = cyc;
    for (int i = 2; i < 6; i++) begin
      wait_for("burst_cs", 0, 1'b1, w);
      sb_check("burst_data");
      wait_for("burst_irq", 1, 1'b1, w);
      check("burst_spacing", cyc - t0, PERIOD);
      t0 = cyc;
    end
    wait_for("burst_done", 2, 1'b0, w);
    check("burst_drained", exp_q.size(), 0);
    check("burst_empty", {31'd0, sif.fifo_empty}, 1);

    // flush five ticks into an IRQ pulse, with a coincident write that must be discarded
    wait_cen(); @(negedge clk_49m);
    exp_q.push_back(8'h3C); wr(8'h3C); wr(8'h3D);
    wait_for("flush_cs", 0, 1'b1, w);
    sb_check("flush_data");
    wait_for("flush_irq", 1, 1'b1, w);
    repeat (5) wait_cen();
    sif.flush = 1'b1; sif.cmd_wr = 1'b1; sif.cmd_din = 8'hEE;
    @(negedge clk_49m);
    sif.flush = 1'b0; sif.cmd_wr = 1'b0;
    t0 = cyc;
    check("flush_irq_low", {31'd0, sif.irq_trigger}, 0);
    check("flush_level", {29'd0, sif.fifo_level}, 0);
    check("flush_empty", {31'd0, sif.fifo_empty}, 1);
    check("flush_busy", {31'd0, sif.busy}, 1);
    check("flush_ovf_kept", {31'd0, sif.overflow}, 1);
    exp_q.push_back(8'h5A); wr(8'h5A);
    wait_for("flush_next_cs", 0, 1'b1, w);
    sb_check("flush_next_data");
    wait_for("flush_next_irq", 1, 1'b1, w);
    check("flush_gap", cyc - t0, (GAP_TICKS + 2) * TICK);
    wait_for("flush_done", 2, 1'b0, w);

    // asynchronous reset while in LATCH
    exp_q.push_back(8'h77); wr(8'h77);
    wait_for("arst_cs", 0, 1'b1, w);
    sb_check("arst_data");
    #3 reset = 1'b0;
    #1 check_reset_vals("arst");
    @(negedge clk_49m);
    reset = 1'b1;
    exp_q.push_back(8'h88); wr(8'h88);
    wait_for("arst_after_cs", 0, 1'b1, w);
    sb_check("arst_after_data");
    wait_for("arst_after_irq", 1, 1'b1, w);
    wait_for("arst_after_done", 2, 1'b0, w);

    // write on the same cycle as an IDLE tick with an empty FIFO
    wait_cen();
    exp_q.push_back(8'hC3);
    sif.cmd_wr = 1'b1; sif.cmd_din = 8'hC3;
    @(negedge clk_49m);
    sif.cmd_wr = 1'b0;
    t0 = cyc;
    check("race_level", {29'd0, sif.fifo_level}, 1);
    check("race_cs", {31'd0, sif.cs_sounddata}, 0);
    wait_for("race_cs_rise", 0, 1'b1, w);
    check("race_delay", cyc - t0, TICK);
    sb_check("race_data");
    wait_for("race_done", 2, 1'b0, w);
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/junofirst_sndcmd_tx.md
Name: junofirst_sndcmd_tx

Overview:
- Main-CPU-board side of the Juno First sound-command link. It queues command bytes written by the main 6809 and replays them toward the sound board.
- Each command goes out as a one-cen_3m-tick latch write on cs_sounddata/cpubrd_Din, followed by a 0->1->0 pulse on irq_trigger.
- A minimum gap is enforced between commands, so the sound Z80 (including in underclock mode) can service each IRQ before the latch is overwritten.
- Sits between the main-CPU address decode and the sound board's soundlatch/IRQ inputs.

Parameters:
- FIFO_AW, 2, log2 of command FIFO depth (depth 4).
- IRQ_HOLD, 16, number of cen_3m ticks irq_trigger is held high (must be >= 1).
- GAP_TICKS, 2048, number of cen_3m ticks irq_trigger is held low after each pulse before the next command may start (must be >= 1).

Ports:
- clk_49m  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cen_3m  in  1  clock enable, one clk_49m cycle per 16.
- cmd_wr  in  1  one-clk strobe from the main-CPU decode: enqueue cmd_din.
- cmd_din  in  8  command byte.
- flush  in  1  synchronous: empty the FIFO and abort the command in flight.
- cs_sounddata  out  1  latch write strobe to the sound board.
- cpubrd_Din  out  8  latch data to the sound board.
- irq_trigger  out  1  sound IRQ trigger; the sound board edge-detects 0->1.
- fifo_level  out  FIFO_AW+1  number of queued bytes.
- fifo_full  out  1  FIFO is full.
- fifo_empty  out  1  FIFO is empty.
- busy  out  1  FSM is not IDLE.
- overflow  out  1  sticky: a write was dropped.
- drop_cnt  out  8  dropped-write count; present only with SNDCMD_DROP_CNT_EN.

Behaviour:
- Reset (asynchronous, reset=0):
  - FSM goes to IDLE; FIFO emptied.
  - Outputs: cs_sounddata=0, cpubrd_Din=8'h00, irq_trigger=0, fifo_level=0, fifo_empty=1, fifo_full=0, busy=0, overflow=0, drop_cnt=0.
- All outputs are registered.
- FIFO:
  - Circular buffer with (FIFO_AW+1)-bit read/write pointers; the MSB is used for full/empty. Pointers wrap modulo 2*depth.
  - cmd_wr is sampled every clk_49m cycle, independent of cen_3m.
  - A write while full is dropped and sets overflow, except when a pop happens in the same cycle; then the write is accepted and the level is unchanged.
  - A write and a pop in the same cycle with the FIFO empty: the pop does not happen (FIFO was empty at that cycle). The byte pops at the next IDLE cen_3m tick.
- FSM: all state transitions occur only on cycles with cen_3m=1.
  - IDLE: if the FIFO is not empty, pop the head into cpubrd_Din, set cs_sounddata=1, go to LATCH.
  - LATCH: on the next cen_3m tick, the receiver samples the latch on this same cycle. Then set cs_sounddata=0, irq_trigger=1, cnt=IRQ_HOLD-1, go to TRIG.
  - TRIG: if cnt==0, set irq_trigger=0, cnt=GAP_TICKS-1, go to GAP; else cnt--.
  - GAP: if cnt==0, go to IDLE; else cnt--.
- Timing:
  - cs_sounddata is high for exactly 16 clk_49m cycles, covering exactly one cen_3m pulse.
  - irq_trigger is high for IRQ_HOLD*16 cycles and low for at least GAP_TICKS*16 cycles between pulses.
  - Back-to-back commands: pulse-start to pulse-start = (1+IRQ_HOLD+GAP_TICKS+1) ticks.
  - Latency from cmd_wr into an idle, empty block to cs_sounddata rising: at most 16 clk_49m cycles plus 1 (first cen_3m after the write is registered).
- cpubrd_Din holds the last transmitted byte until the next pop; it is never tristated or zeroed.
- busy=1 in LATCH, TRIG and GAP.
- flush, highest priority after reset, acts on any cycle (not gated by cen_3m):
  - Pointers are cleared and cs_sounddata=0.
  - From LATCH or TRIG: irq_trigger=0, go to GAP with cnt=GAP_TICKS-1, so the low interval is still guaranteed.
  - From GAP: cnt is not restarted.
  - From IDLE: stays in IDLE.
  - overflow is not cleared by flush.
  - A cmd_wr in the same cycle as flush is discarded.

Optional Feature:
- Macro SNDCMD_DROP_CNT_EN.
- Defined: drop_cnt is an 8-bit counter that increments on each dropped write and saturates at 8'hFF. It is cleared only by reset.
- Undefined: the drop_cnt port and its logic are absent; overflow still operates.

Test Plan:
- Single command: one cmd_wr with 8'hA5 into an idle block -> cs_sounddata high for 16 clk covering one cen_3m with cpubrd_Din=8'hA5. irq_trigger rises on the next tick and stays high 256 clk, then low; busy drops 2048*16 clk later.
- Burst: 4 writes 01,02,03,04 on consecutive clk -> fifo_full=1, level=4. Bytes go out in order; rising edges of irq_trigger are exactly (2+16+2048)*16 clk apart.
- Overflow: 5 writes while no pop is possible -> 5th byte dropped, overflow=1, level=4, drop_cnt=1 (with the macro). A write coinciding with a pop while full is accepted.
- Flush mid-TRIG: flush 5 ticks into a pulse -> irq_trigger=0 next clk, level=0, full GAP_TICKS low interval observed before any new command.
- Async reset mid-LATCH: reset asserted -> all outputs reach their reset values without a clock edge. After release, a new write is transmitted normally.
- Empty-write-pop race: cmd_wr coincident with an IDLE cen_3m tick on an empty FIFO -> the byte is transmitted starting at the following cen_3m tick.
